// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock, WIDTH cycles per operation.
// Optional signed-overflow output is enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
    logic [WIDTH-1:0] res_sh_next;
    logic [WIDTH-1:0] diff_reg;
    logic [CW-1:0]    cnt_reg;
    logic             br_reg, br_next;
    logic             bout_reg;
    logic             d_bit, ai, bi;
    logic             accept, last_bit;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_reg;
`endif

    assign accept   = start && (state_reg == IDLE || state_reg == DONE);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign ai          = a_sh_reg[0];
    assign bi          = b_sh_reg[0];
    assign d_bit       = ai ^ bi ^ br_reg;
    assign br_next     = (~ai & bi) | (~(ai ^ bi) & br_reg);
    assign res_sh_next = (res_sh_reg >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            diff_reg   <= '0;
            cnt_reg    <= '0;
            br_reg     <= 1'b0;
            bout_reg   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_sh_reg   <= a;
                b_sh_reg   <= b;
                br_reg     <= bin;
                cnt_reg    <= '0;
                res_sh_reg <= '0;
            end else if (state_reg == RUN) begin
                a_sh_reg   <= a_sh_reg >> 1;
                b_sh_reg   <= b_sh_reg >> 1;
                br_reg     <= br_next;
                cnt_reg    <= cnt_reg + 1'b1;
                res_sh_reg <= res_sh_next;
                // Publish the result as DONE is entered; held until the next completion.
                if (last_bit) begin
                    diff_reg <= res_sh_next;
                    bout_reg <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    ovf_reg  <= br_reg ^ br_next;
`endif
                end
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign diff = diff_reg;
    assign bout = bout_reg;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
// Overflow checks are compiled in when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, bin, busy, done, bout;
    logic [7:0] a, b, diff;
    logic       start1, a1, b1, bin1, busy1, done1, diff1, bout1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic       ovf, ovf1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(ovf1)
`endif
    );

    // Reference model: plain integer arithmetic on the operand values.
    function automatic longint ref_diff(int w, longint av, longint bv, longint cv);
        return (av - bv - cv) & ((longint'(1) << w) - 1);
    endfunction

    function automatic logic ref_bout(longint av, longint bv, longint cv);
        return (av < bv + cv);
    endfunction

    function automatic logic ref_ovf(int w, longint av, longint bv, longint cv);
        longint half, sa, sb, r;
        half = longint'(1) << (w - 1);
        sa = (av >= half) ? av - 2 * half : av;
        sb = (bv >= half) ? bv - 2 * half : bv;
        r  = sa - sb - cv;
        return (r < -half) || (r > half - 1);
    endfunction

    // Drives one operation on the 8-bit instance and reports what was observed.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          output logic [7:0] d_o, output logic bo_o, output logic ov_o,
                          output int lat, output int busy_cnt, output logic done_after);
        @(negedge clk);
        a = av; b = bv; bin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        lat = 1; busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        d_o = diff; bo_o = bout; ov_o = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ov_o = ovf;
`endif
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b diff=%h bout=%b want all 0", busy, done, diff, bout);
        end
        checks++;
        if ({busy1, done1, diff1, bout1} !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs_w1 got busy=%b done=%b diff=%b bout=%b want all 0", busy1, done1, diff1, bout1);
        end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", ovf);
        end
`endif
        rst = 1'b0; start = 1'b0; start1 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
        $display("reset: busy=%b done=%b diff=%h bout=%b", busy, done, diff, bout);
    endtask

    task automatic test_vectors();
        logic [7:0] d; logic bo, ov, da; int lat, bc;
        logic [7:0] av, bv; logic cv;
        for (int i = 0; i < 24; i++) begin
            case (i)
                0: begin av = 8'h05; bv = 8'h03; cv = 1'b0; end
                1: begin av = 8'h03; bv = 8'h05; cv = 1'b0; end
                2: begin av = 8'h00; bv = 8'h00; cv = 1'b1; end
                3: begin av = 8'h80; bv = 8'h01; cv = 1'b0; end
                4: begin av = 8'hFF; bv = 8'hFF; cv = 1'b1; end
                default: begin
                    av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
                end
            endcase
            run_op(av, bv, cv, d, bo, ov, lat, bc, da);
            checks++;
            if (lat !== 9 || bc !== 8 || da !== 1'b0) begin
                errors++;
                $display("FAIL timing[%0d] got lat=%0d busy=%0d done_after=%b want 9 8 0", i, lat, bc, da);
            end
            checks++;
            if (d !== 8'(ref_diff(8, av, bv, cv)) || bo !== ref_bout(av, bv, cv)) begin
                errors++;
                $display("FAIL result[%0d] %h-%h-%b got diff=%h bout=%b want diff=%h bout=%b",
                         i, av, bv, cv, d, bo, 8'(ref_diff(8, av, bv, cv)), ref_bout(av, bv, cv));
            end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            checks++;
            if (ov !== ref_ovf(8, av, bv, cv)) begin
                errors++;
                $display("FAIL ovf[%0d] %h-%h-%b got %b want %b", i, av, bv, cv, ov, ref_ovf(8, av, bv, cv));
            end
`endif
            checks++;
            if (diff !== d) begin
                errors++;
                $display("FAIL hold[%0d] got diff=%h want %h", i, diff, d);
            end
            $display("op %h - %h - %b -> diff=%h bout=%b ovf=%b lat=%0d", av, bv, cv, d, bo, ov, lat);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'h01; start = 1'b1;  // RUN cycle 3
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        lat = 4;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9 || diff !== 8'h0F || bout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d diff=%h bout=%b want 9 0f 0", lat, diff, bout);
        end
        $display("ignore_start: diff=%h bout=%b lat=%0d", diff, bout, lat);
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [7:0] d; logic bo, ov, da; int lat, bc, seen;
        @(negedge clk);
        a = 8'h5A; b = 8'h21; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;  // RUN cycle 4
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear got busy=%b done=%b diff=%h bout=%b want 0 0 00 0", busy, done, diff, bout);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done cycles want 0", seen);
        end
        run_op(8'h37, 8'h12, 1'b1, d, bo, ov, lat, bc, da);
        checks++;
        if (lat !== 9 || d !== 8'h24 || bo !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart got lat=%0d diff=%h bout=%b want 9 24 0", lat, d, bo);
        end
        $display("reset_abort: restart diff=%h bout=%b lat=%0d", d, bo, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] first_d; logic first_bo;
        @(negedge clk);
        a = 8'h42; b = 8'h17; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        first_d = diff; first_bo = bout;
        a = 8'h17; b = 8'h42; bin = 1'b0; start = 1'b1;  // DONE cycle
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (first_d !== 8'h2A || first_bo !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got diff=%h bout=%b busy=%b want 2a 0 1", first_d, first_bo, busy);
        end
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9 || diff !== 8'hD5 || bout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d diff=%h bout=%b want 9 d5 1", lat, diff, bout);
        end
        $display("back_to_back: first=%h/%b second=%h/%b lat=%0d", first_d, first_bo, diff, bout, lat);
        @(negedge clk);
    endtask

    task automatic test_width1();
        int lat;
        logic av, bv, cv;
        for (int v = 0; v < 8; v++) begin
            av = v[2]; bv = v[1]; cv = v[0];
            @(negedge clk);
            a1 = av; b1 = bv; bin1 = cv; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            lat = 1;
            while (!done1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== 2 || diff1 !== 1'(ref_diff(1, av, bv, cv)) || bout1 !== ref_bout(av, bv, cv)) begin
                errors++;
                $display("FAIL width1 %b-%b-%b got lat=%0d diff=%b bout=%b want 2 %b %b",
                         av, bv, cv, lat, diff1, bout1, 1'(ref_diff(1, av, bv, cv)), ref_bout(av, bv, cv));
            end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            checks++;
            if (ovf1 !== ref_ovf(1, av, bv, cv)) begin
                errors++;
                $display("FAIL width1_ovf %b-%b-%b got %b want %b", av, bv, cv, ovf1, ref_ovf(1, av, bv, cv));
            end
`endif
            $display("width1 %b - %b - %b -> diff=%b bout=%b lat=%0d", av, bv, cv, diff1, bout1, lat);
        end
    endtask

    initial begin
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one subtraction.
REQ-005 SHALL have port a  input  WIDTH  minuend, sampled only when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, sampled only when start is accepted.
REQ-007 SHALL have port bin  input  1  borrow-in, sampled only when start is accepted.
REQ-008 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when diff and bout are valid.
REQ-010 SHALL have port diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  final borrow-out; 1 when a < b + bin unsigned.

Function
REQ-012 SHALL implement the three-state FSM IDLE -> RUN -> DONE -> IDLE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance, latch a, b and bin, clear the bit counter, and enter RUN.
REQ-014 SHALL ignore start while in RUN; the latched operands are not disturbed.
REQ-015 SHALL, in RUN, process one bit per cycle, LSB first, using a full-subtractor cell: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-016 SHALL shift each d into the result register from the MSB end, so that after WIDTH cycles diff[0] holds bit 0.
REQ-017 SHALL leave RUN after exactly WIDTH cycles, with WIDTH = 1 taking one cycle.
REQ-018 SHALL assert done during the DONE state for exactly one cycle, which is WIDTH+1 cycles after the start-accept edge, then return to IDLE.
REQ-019 SHALL hold busy high for exactly the WIDTH RUN cycles.
REQ-020 SHALL update diff and bout when DONE is entered and hold them stable until the next completion or reset.
REQ-021 SHALL accept a start asserted during the DONE cycle, going directly to RUN with no IDLE cycle (back-to-back operation).
REQ-022 SHALL size the bit counter as clog2(WIDTH)+1 bits so it cannot wrap before terminal count.

Reset
REQ-023 SHALL, while rst is high, force the state to IDLE and clear busy, done, diff, bout, the counter, the borrow flop and the operand shift registers, regardless of start.
REQ-024 SHALL let rst asserted mid-RUN abort the operation with no done pulse; the first start after rst deasserts is accepted normally.

Configuration
REQ-025 SHALL, when macro SERIAL_SUBTRACTOR_OVF_EN is defined, add output port ovf (1 bit) = signed two's-complement overflow of a - b - bin, computed as borrow into MSB XOR borrow out of MSB.
REQ-026 SHALL give ovf the same update, hold and reset rules as bout.
REQ-027 SHALL, when SERIAL_SUBTRACTOR_OVF_EN is undefined, omit the ovf port and its logic entirely, leaving all other behaviour unchanged.

Verification
REQ-028 SHALL cover: WIDTH=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, done exactly 9 cycles after the start-accept edge, busy high for 8 cycles.
REQ-029 SHALL cover: a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; and a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-030 SHALL cover: start pulsed with a=0xFF, b=0x01 during cycle 3 of RUN on 0x10-0x01 -> ignored; result diff=0x0F, bout=0.
REQ-031 SHALL cover: rst for 1 cycle at RUN cycle 4 -> no done pulse; diff=0x00, bout=0, busy=0 next cycle; a new start then completes correctly.
REQ-032 SHALL cover: back-to-back start in the DONE cycle -> second result valid 9 cycles later; also WIDTH=1, a=0, b=1 -> diff=1, bout=1, done 2 cycles after start.
REQ-033 SHALL cover, with SERIAL_SUBTRACTOR_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x05, b=0x03 -> ovf=0.
